// File: rtl/edge_pkg.sv
// Shared types and constants for the gradient-stage anchor scheduler.
// The filter window is 16 pixels wide and yields 14 valid output columns.
package edge_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MOVE,
        S_ARM,
        S_WAIT_GRAD,
        S_RESULT,
        S_ADVANCE,
        S_DONE
    } sched_state_t;

    localparam int unsigned GRAD_WINDOW = 16;
    localparam int unsigned GRAD_OUT    = GRAD_WINDOW - 2;

    // Widened to 17 bits so the strip step cannot wrap near the 16-bit limit.
    function automatic logic [16:0] next_strip_x(input logic [15:0] x, input int unsigned strip);
        return {1'b0, x} + 17'(strip);
    endfunction

endpackage

// File: rtl/anchor_position_counter.sv
// Anchor x/y counters: rows advance within a strip, then the strip steps right.
// Exposes last-row and last-strip flags for the scheduler FSM.
module anchor_position_counter
    import edge_pkg::*;
#(
    parameter int unsigned IMG_W  = 320,
    parameter int unsigned IMG_H  = 240,
    parameter int unsigned STRIP  = GRAD_OUT,
    parameter int unsigned Y_INIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_advance,
    output logic [15:0] o_x,
    output logic [15:0] o_y,
    output logic        o_last_row,
    output logic        o_last_strip
);

    localparam logic [15:0] LAST_Y = 16'(Y_INIT + IMG_H - 1);
    localparam logic [15:0] FIRST_Y = 16'(Y_INIT);
    localparam logic [16:0] WIDTH17 = 17'(IMG_W);

    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [16:0] w_x_next;

    assign w_x_next     = next_strip_x(r_x, STRIP);
    assign o_last_row   = (r_y == LAST_Y);
    assign o_last_strip = (w_x_next >= WIDTH17);
    assign o_x          = r_x;
    assign o_y          = r_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= FIRST_Y;
        end else if (i_load) begin
            r_x <= '0;
            r_y <= FIRST_Y;
        end else if (i_advance) begin
            if (!o_last_row) begin
                r_y <= r_y + 16'd1;
            end else if (!o_last_strip) begin
                r_x <= w_x_next[15:0];
                r_y <= FIRST_Y;
            end
            // last row of last strip: hold final position for the frame_done cycle
        end
    end

endmodule

// File: rtl/gradient_anchor_scheduler.sv
// Frame-level sequencer: walks the 3-row filter anchor over the image in column strips,
// handshaking line-buffer fetch, gradient controller kick/complete and downstream hand-off.
module gradient_anchor_scheduler
    import edge_pkg::*;
#(
    parameter int unsigned IMG_W  = 320,
    parameter int unsigned IMG_H  = 240,
    parameter int unsigned STRIP  = GRAD_OUT,
    parameter int unsigned Y_INIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        fetch_req,
    input  logic        fetch_ack,
    output logic        anchor_moving,
    output logic [15:0] anchor_x,
    output logic [15:0] anchor_y,
    input  logic        gradient_final,
    output logic        result_valid,
    input  logic        result_ready,
    output logic        strip_last,
    output logic        frame_done,
    output logic        busy
);

    sched_state_t r_state;
    logic         r_fetch_req;
    logic         r_moving;
    logic         r_result_valid;
    logic         r_strip_last;
    logic         r_frame_done;
    logic         r_busy;

    logic         w_load;
    logic         w_advance;
    logic         w_last_row;
    logic         w_last_strip;

    assign w_load    = (r_state == S_IDLE) && start;
    assign w_advance = (r_state == S_ADVANCE);

    anchor_position_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .STRIP  (STRIP),
        .Y_INIT (Y_INIT)
    ) u_pos (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load),
        .i_advance    (w_advance),
        .o_x          (anchor_x),
        .o_y          (anchor_y),
        .o_last_row   (w_last_row),
        .o_last_strip (w_last_strip)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_fetch_req    <= 1'b0;
            r_moving       <= 1'b0;
            r_result_valid <= 1'b0;
            r_strip_last   <= 1'b0;
            r_frame_done   <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_FETCH;
                        r_fetch_req <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (fetch_ack) begin
                        r_state     <= S_MOVE;
                        r_fetch_req <= 1'b0;
                        r_moving    <= 1'b1;
                    end
                end
                S_MOVE: begin
                    r_state  <= S_ARM;
                    r_moving <= 1'b0;
                end
                // Controller's final flag may still read high here from before the kick.
                S_ARM: begin
                    r_state <= S_WAIT_GRAD;
                end
                S_WAIT_GRAD: begin
                    if (gradient_final) begin
                        r_state        <= S_RESULT;
                        r_result_valid <= 1'b1;
                        r_strip_last   <= w_last_row;
                    end
                end
                S_RESULT: begin
                    if (result_ready) begin
                        r_state        <= S_ADVANCE;
                        r_result_valid <= 1'b0;
                        r_strip_last   <= 1'b0;
                    end
                end
                S_ADVANCE: begin
                    if (w_last_row && w_last_strip) begin
                        r_state      <= S_DONE;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_state     <= S_FETCH;
                        r_fetch_req <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state      <= S_IDLE;
                    r_frame_done <= 1'b0;
                    r_busy       <= 1'b0;
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_fetch_req    <= 1'b0;
                    r_moving       <= 1'b0;
                    r_result_valid <= 1'b0;
                    r_strip_last   <= 1'b0;
                    r_frame_done   <= 1'b0;
                    r_busy         <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_req     = r_fetch_req;
    assign anchor_moving = r_moving;
    assign result_valid  = r_result_valid;
    assign strip_last    = r_strip_last;
    assign frame_done    = r_frame_done;
    assign busy          = r_busy;

endmodule

// File: tb/tb_gradient_anchor_scheduler.sv
// Scoreboard bench: two schedulers (28- and 30-pixel-wide frames, 4 rows) with gradient
// controller models; expected anchors are queued at frame start and popped on each row hand-off.
module tb_gradient_anchor_scheduler;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a, ack_a, ready_a, force_final;
    logic        start_b, ack_b, ready_b;

    logic        fr_a, mov_a, rv_a, sl_a, fd_a, busy_a, final_a;
    logic [15:0] ax, ay;
    logic        fr_b, mov_b, rv_b, sl_b, fd_b, busy_b, final_b;
    logic [15:0] bx, by;

    logic [4:0]  cnt_a, cnt_b;

    exp_t qa[$];
    exp_t qb[$];
    exp_t e_a, e_b;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int kicks_a = 0, dones_a = 0, kick_cyc_a = 0;
    int kicks_b = 0, dones_b = 0;
    logic prev_valid_a = 1'b0;

    gradient_anchor_scheduler #(.IMG_W(28), .IMG_H(4), .STRIP(14), .Y_INIT(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .fetch_req(fr_a), .fetch_ack(ack_a), .anchor_moving(mov_a),
        .anchor_x(ax), .anchor_y(ay), .gradient_final(final_a),
        .result_valid(rv_a), .result_ready(ready_a), .strip_last(sl_a),
        .frame_done(fd_a), .busy(busy_a)
    );

    gradient_anchor_scheduler #(.IMG_W(30), .IMG_H(4), .STRIP(14), .Y_INIT(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .fetch_req(fr_b), .fetch_ack(ack_b), .anchor_moving(mov_b),
        .anchor_x(bx), .anchor_y(by), .gradient_final(final_b),
        .result_valid(rv_b), .result_ready(ready_b), .strip_last(sl_b),
        .frame_done(fd_b), .busy(busy_b)
    );

    // Gradient controller models: final high when idle, low for 17 cycles after a kick.
    always @(posedge clk or posedge rst) begin
        if (rst) cnt_a <= '0;
        else if (mov_a) cnt_a <= 5'd17;
        else if (cnt_a != 5'd0) cnt_a <= cnt_a - 5'd1;
    end
    always @(posedge clk or posedge rst) begin
        if (rst) cnt_b <= '0;
        else if (mov_b) cnt_b <= 5'd17;
        else if (cnt_b != 5'd0) cnt_b <= cnt_b - 5'd1;
    end
    assign final_a = (cnt_a == 5'd0) || force_final;
    assign final_b = (cnt_b == 5'd0);

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame(input int w, input bit to_b);
        exp_t e;
        for (int x = 0; x < w; x += 14) begin
            for (int y = 2; y <= 5; y++) begin
                e.x    = 16'(x);
                e.y    = 16'(y);
                e.last = (y == 5);
                if (to_b) qb.push_back(e);
                else      qa.push_back(e);
            end
        end
    endtask

    task automatic pulse_start_a();
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
    endtask

    task automatic wait_frame_a(input int budget);
        int d0 = dones_a;
        int i  = 0;
        while (dones_a == d0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("a_frame_done_seen", 64'(dones_a - d0), 64'd1);
    endtask

    // Monitor A: anchor at each kick, kick-to-result latency, scoreboard pop on hand-off.
    always @(negedge clk) begin
        if (!rst) begin
            if (mov_a) begin
                kicks_a++;
                kick_cyc_a = cyc;
                check("a_kick_qnonempty", 64'(qa.size() != 0), 64'd1);
                if (qa.size() != 0) check("a_kick_xy", 64'({ax, ay}), 64'({qa[0].x, qa[0].y}));
            end
            if (rv_a && !prev_valid_a) check("a_kick_to_valid", 64'(cyc - kick_cyc_a), 64'd19);
            if (rv_a && ready_a) begin
                check("a_result_qnonempty", 64'(qa.size() != 0), 64'd1);
                if (qa.size() != 0) begin
                    e_a = qa.pop_front();
                    check("a_result", 64'({ax, ay, sl_a}), 64'({e_a.x, e_a.y, e_a.last}));
                end
            end
            if (fd_a) dones_a++;
        end
        prev_valid_a = rv_a;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (mov_b) kicks_b++;
            if (rv_b && ready_b) begin
                check("b_result_qnonempty", 64'(qb.size() != 0), 64'd1);
                if (qb.size() != 0) begin
                    e_b = qb.pop_front();
                    check("b_result", 64'({fr_b, bx, by, sl_b}), 64'({1'b0, e_b.x, e_b.y, e_b.last}));
                end
            end
            if (fd_b) dones_b++;
        end
    end

    initial begin
        int k0, d0, i;
        rst = 1'b1; start_a = 1'b0; ack_a = 1'b1; ready_a = 1'b1; force_final = 1'b0;
        start_b = 1'b0; ack_b = 1'b1; ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_a_flags", 64'({fr_a, mov_a, rv_a, sl_a, fd_a, busy_a}), 64'd0);
        check("reset_a_xy", 64'({ax, ay}), 64'({16'd0, 16'd2}));
        check("reset_b_state", 64'({fr_b, mov_b, rv_b, fd_b, busy_b, bx, by}), 64'({5'd0, 16'd0, 16'd2}));
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy_a", 64'(busy_a), 64'd0);

        // Frame 1: everything tied ready.
        k0 = kicks_a;
        push_frame(28, 1'b0);
        pulse_start_a();
        wait_frame_a(3000);
        @(negedge clk);
        check("f1_kicks", 64'(kicks_a - k0), 64'd8);
        check("f1_busy_after", 64'(busy_a), 64'd0);
        check("f1_xy_hold", 64'({ax, ay}), 64'({16'd14, 16'd5}));
        check("f1_q_empty", 64'(qa.size()), 64'd0);

        // Frame 2: fetch stall, final high across ARM, downstream back-pressure.
        ack_a = 1'b0;
        push_frame(28, 1'b0);
        pulse_start_a();
        @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            check("stall_fetch_req", 64'({fr_a, mov_a}), 64'({1'b1, 1'b0}));
            check("stall_xy", 64'({ax, ay}), 64'({16'd0, 16'd2}));
            @(negedge clk);
        end
        @(posedge clk); #1 ack_a = 1'b1; ready_a = 1'b0;
        i = 0;
        while (!mov_a && i < 50) begin @(negedge clk); i++; end
        check("kick_seen", 64'(mov_a), 64'd1);
        force_final = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 force_final = 1'b0;
        i = 0;
        while (!rv_a && i < 60) begin @(negedge clk); i++; end
        check("valid_seen", 64'(rv_a), 64'd1);
        for (int n = 0; n < 10; n++) begin
            check("bp_hold", 64'({rv_a, sl_a, ax, ay}), 64'({1'b1, 1'b0, 16'd0, 16'd2}));
            @(negedge clk);
        end
        @(posedge clk); #1 ready_a = 1'b1;
        wait_frame_a(3000);
        check("f2_q_empty", 64'(qa.size()), 64'd0);

        // Frame 3: reset while waiting on the gradient of row 3.
        k0 = kicks_a;
        d0 = dones_a;
        push_frame(28, 1'b0);
        pulse_start_a();
        i = 0;
        while (kicks_a < k0 + 3 && i < 500) begin @(negedge clk); i++; end
        check("f3_row3_kicked", 64'(kicks_a - k0), 64'd3);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_flags", 64'({fr_a, mov_a, rv_a, sl_a, fd_a, busy_a}), 64'd0);
        check("midrst_xy", 64'({ax, ay}), 64'({16'd0, 16'd2}));
        qa.delete();
        @(posedge clk); #1 rst = 1'b0;
        repeat (30) @(negedge clk);
        check("post_rst_idle", 64'({busy_a, fr_a}), 64'd0);
        check("post_rst_no_done", 64'(dones_a - d0), 64'd0);

        // Frame 4: start pulses while busy must not spawn another frame.
        k0 = kicks_a;
        d0 = dones_a;
        push_frame(28, 1'b0);
        pulse_start_a();
        i = 0;
        while (kicks_a < k0 + 2 && i < 500) begin @(negedge clk); i++; end
        repeat (3) pulse_start_a();
        wait_frame_a(3000);
        repeat (40) @(negedge clk);
        check("f4_single_done", 64'(dones_a - d0), 64'd1);
        check("f4_kicks", 64'(kicks_a - k0), 64'd8);
        check("f4_idle", 64'({busy_a, fr_a}), 64'd0);

        // Partial third strip on the 30-wide instance.
        k0 = kicks_b;
        d0 = dones_b;
        push_frame(30, 1'b1);
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        i = 0;
        while (dones_b == d0 && i < 4000) begin @(negedge clk); i++; end
        check("b_frame_done_seen", 64'(dones_b - d0), 64'd1);
        @(negedge clk);
        check("b_kicks", 64'(kicks_b - k0), 64'd12);
        check("b_final_xy", 64'({bx, by}), 64'({16'd28, 16'd5}));
        check("b_idle", 64'(busy_b), 64'd0);
        check("b_q_empty", 64'(qb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
